intr_ctrl: RTL and testbench

Interrupt/exception controller for the pipelined CPU. It sits in the EX stage, directly upstream of the Cause and EPC registers. It arbitrates synchronous exceptions and a latched external interrupt, then produces the Cause write data and write strobe, the EPC value, the pipeline flush and the PC redirect. It also sequences ERET return.

---
 rtl/intr_ctrl.sv | 131 +++++++++++++
 tb/tb_intr_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt/exception controller for the EX stage: arbitrates exceptions and a latched
// external interrupt, drives Cause/EPC writes, flush and PC redirect. Define INTR_SYNC_EN for a 2-FF ext_intr synchronizer.
module intr_ctrl #(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_intr,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic [31:0] ex_pc,
  input  logic        exc_ov,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        eret,
  input  logic [31:0] epc_q,
  output logic [31:0] cause_data,
  output logic        cause_write,
  output logic [31:0] epc_data,
  output logic        epc_write,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        in_handler,
  output logic        nested_err
);

  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;

  state_t      state, state_nxt;
  logic        ext_in, ext_prev, rise;
  logic        pending, nested_err_q;
  logic        exc_any, take, take_ext, ret;
  logic [1:0]  exccode;

`ifdef INTR_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ext_intr;
      sync2 <= sync1;
    end
  end

  assign ext_in = sync2;
`else
  assign ext_in = ext_intr;
`endif

  assign rise     = ext_in & ~ext_prev;
  assign exc_any  = exc_ov | exc_ri | exc_sys;
  assign take     = (state == IDLE) & ex_valid & ~stall & (exc_any | pending);
  assign take_ext = take & ~exc_any;
  assign ret      = (state == HANDLER) & ex_valid & ~stall & eret;

  always_comb begin
    exccode = 2'b00;
    if (exc_ov)       exccode = 2'b11;
    else if (exc_ri)  exccode = 2'b10;
    else if (exc_sys) exccode = 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ext_prev     <= 1'b0;
      pending      <= 1'b0;
      nested_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      ext_prev <= ext_in;
      // a new edge in the same cycle as the take must not be lost
      pending  <= rise | (pending & ~take_ext);
      if ((state == HANDLER) && ex_valid && exc_any)
        nested_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cause_data  = '0;
    cause_write = 1'b0;
    epc_data    = '0;
    epc_write   = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    in_handler  = 1'b0;
    nested_err  = 1'b0;
    if (!rst) begin
      nested_err = nested_err_q;
      case (state)
        IDLE: begin
          if (take) begin
            cause_write = 1'b1;
            cause_data  = {28'b0, exccode, 2'b00};
            epc_write   = 1'b1;
            epc_data    = (exccode == 2'b01) ? ex_pc + 32'd4 : ex_pc;
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = HANDLER_VEC;
            state_nxt   = ENTER;
          end
        end
        ENTER: begin
          flush     = 1'b1;
          state_nxt = HANDLER;
        end
        HANDLER: begin
          in_handler = 1'b1;
          if (ret) begin
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = epc_q;
            state_nxt   = RETURN;
          end
        end
        RETURN: begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst, ext_intr, ex_valid, stall, exc_ov, exc_ri, exc_sys, eret;
  logic [31:0] ex_pc, epc_q;
  logic [31:0] cause_data, epc_data, redirect_pc;
  logic        cause_write, epc_write, flush, redirect, in_handler, nested_err;

  int checks = 0;
  int errors = 0;

`ifdef INTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int M_IDLE = 0, M_ENTER = 1, M_HANDLER = 2, M_RETURN = 3;

  // model state
  int          m_mode;
  bit          m_pend, m_nerr;
  bit          samp [0:3];

  // per-cycle observed / expected: {cw,ew,flush,redirect,in_handler,nested_err,cause,epc,rpc}
  logic [101:0] obs, exp;
  logic [31:0]  a_cause, a_epc, a_rpc;
  logic [5:0]   a_ctl;

  always #5 clk = ~clk;

  intr_ctrl #(.HANDLER_VEC(32'h0000_0004)) dut (
    .clk(clk), .rst(rst), .ext_intr(ext_intr), .ex_valid(ex_valid), .stall(stall),
    .ex_pc(ex_pc), .exc_ov(exc_ov), .exc_ri(exc_ri), .exc_sys(exc_sys), .eret(eret),
    .epc_q(epc_q), .cause_data(cause_data), .cause_write(cause_write),
    .epc_data(epc_data), .epc_write(epc_write), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .in_handler(in_handler), .nested_err(nested_err)
  );

  task automatic idle_inputs();
    ex_valid = 0; stall = 0; exc_ov = 0; exc_ri = 0; exc_sys = 0; eret = 0;
  endtask

  // Predict this cycle's outputs at the negedge, sample the DUT, then advance the model
  // to the next rising edge. Returns #1 after that edge.
  task automatic step();
    bit exc, take, ret, rise;
    logic [5:0]  ec;
    logic [31:0] ecause, eepc, erpc;
    @(negedge clk);
    exc    = exc_ov || exc_ri || exc_sys;
    take   = !rst && m_mode == M_IDLE && ex_valid && !stall && (exc || m_pend);
    ret    = !rst && m_mode == M_HANDLER && ex_valid && !stall && eret;
    ecause = exc_ov ? 32'd12 : exc_ri ? 32'd8 : exc_sys ? 32'd4 : 32'd0;
    eepc   = (exc_sys && !exc_ov && !exc_ri) ? ex_pc + 32'd4 : ex_pc;
    erpc   = take ? 32'h4 : epc_q;
    ec     = rst ? 6'b0 : {take, take, take || ret || m_mode == M_ENTER || m_mode == M_RETURN,
                           take || ret, m_mode == M_HANDLER, m_nerr};
    a_cause = cause_data; a_epc = epc_data; a_rpc = redirect_pc;
    a_ctl   = {cause_write, epc_write, flush, redirect, in_handler, nested_err};
    exp = {ec, ec[5] ? ecause : 32'd0, ec[4] ? eepc : 32'd0, ec[2] ? erpc : 32'd0};
    obs = {a_ctl, ec[5] ? cause_data : 32'd0, ec[4] ? epc_data : 32'd0,
           ec[2] ? redirect_pc : 32'd0};
    if (rst) begin
      m_mode = M_IDLE; m_pend = 0; m_nerr = 0;
      for (int i = 0; i < 4; i++) samp[i] = 0;
    end else begin
      if (m_mode == M_HANDLER && ex_valid && exc) m_nerr = 1;
      for (int i = 3; i > 0; i--) samp[i] = samp[i-1];
      samp[0] = ext_intr;
      rise = samp[LAT] && !samp[LAT+1];
      if (take && !exc) m_pend = 0;
      if (rise) m_pend = 1;
      if (take)                    m_mode = M_ENTER;
      else if (ret)                m_mode = M_RETURN;
      else if (m_mode == M_ENTER)  m_mode = M_HANDLER;
      else if (m_mode == M_RETURN) m_mode = M_IDLE;
    end
    @(posedge clk);
    #1;
  endtask

  // Called right after a take cycle: ENTER, eret in HANDLER, RETURN.
  task automatic leave_handler(input logic [31:0] ret_pc);
    idle_inputs();
    step();
    checks++; if (obs !== exp || a_ctl[3] !== 1'b1) begin errors++; $display("FAIL enter_cycle act=%h exp=%h", obs, exp); end
    ex_valid = 1; eret = 1; epc_q = ret_pc;
    step();
    checks++; if (obs !== exp || a_rpc !== ret_pc || a_ctl[2] !== 1'b1) begin errors++; $display("FAIL eret_cycle act=%h exp=%h rpc=%h", obs, exp, a_rpc); end
    idle_inputs();
    step();
    checks++; if (obs !== exp || a_ctl[5:2] !== 4'b0010) begin errors++; $display("FAIL return_cycle act=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset();
    rst = 1; ext_intr = 0; ex_pc = 32'h40; epc_q = 0;
    idle_inputs();
    ex_valid = 1; exc_ov = 1;
    step();
    checks++; if (obs !== exp || {a_ctl, a_cause, a_epc, a_rpc} !== '0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", {a_ctl, a_cause, a_epc, a_rpc}); end
    rst = 0; idle_inputs();
    step();
    checks++; if (obs !== exp || a_ctl !== 6'b0) begin errors++; $display("FAIL reset_idle act=%h exp=%h", obs, exp); end
  endtask

  task automatic test_overflow();
    ex_valid = 1; exc_ov = 1; ex_pc = 32'h40;
    step();
    checks++; if (obs !== exp || a_cause !== 32'hC || a_epc !== 32'h40 || a_rpc !== 32'h4 || a_ctl !== 6'b111100) begin
      errors++; $display("FAIL take_ov act=%h exp=%h cause=%h epc=%h", obs, exp, a_cause, a_epc); end
    leave_handler(32'h44);
  endtask

  task automatic test_priority();
    ex_valid = 1; exc_sys = 1; exc_ri = 1; ex_pc = 32'h100;
    step();
    checks++; if (obs !== exp || a_cause !== 32'h8 || a_epc !== 32'h100) begin errors++; $display("FAIL prio_ri_sys act=%h exp=%h", obs, exp); end
    leave_handler(32'h104);
    ex_valid = 1; exc_sys = 1; ex_pc = 32'h100;
    step();
    checks++; if (obs !== exp || a_cause !== 32'h4 || a_epc !== 32'h104) begin errors++; $display("FAIL sys_only act=%h exp=%h", obs, exp); end
    leave_handler(32'h104);
    ex_valid = 1; exc_sys = 1; ex_pc = 32'hFFFF_FFFC;
    step();
    checks++; if (obs !== exp || a_epc !== 32'h0) begin errors++; $display("FAIL sys_wrap act=%h exp=0", a_epc); end
    leave_handler(32'h0);
  endtask

  task automatic test_ext_intr();
    int got = -1;
    logic [31:0] cc = '1, ce = '0;
    ext_intr = 1; ex_valid = 1; ex_pc = 32'h300;
    for (int i = 0; i < 8 && got < 0; i++) begin
      step();
      checks++; if (obs !== exp) begin errors++; $display("FAIL ext_wait act=%h exp=%h", obs, exp); end
      if (a_ctl[5]) begin got = i; cc = a_cause; ce = a_epc; end
    end
    checks++; if (got != LAT + 1) begin errors++; $display("FAIL ext_latency act=%0d exp=%0d", got, LAT + 1); end
    checks++; if (cc !== 32'h0 || ce !== 32'h300) begin errors++; $display("FAIL ext_take cause=%h epc=%h exp=0/300", cc, ce); end
    ext_intr = 0;
    leave_handler(32'h300);
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1;
      step();
      checks++; if (obs !== exp || a_ctl[5] !== 1'b0) begin errors++; $display("FAIL ext_cleared act=%h exp=%h", obs, exp); end
    end
  endtask

  task automatic test_mask_return();
    ex_valid = 1; exc_ov = 1; ex_pc = 32'h40;
    step();
    idle_inputs();
    step();
    ext_intr = 1; ex_valid = 1; ex_pc = 32'h600;
    step();
    ext_intr = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      checks++; if (obs !== exp || a_ctl[5] !== 1'b0 || a_ctl[1] !== 1'b1) begin errors++; $display("FAIL masked act=%h exp=%h", obs, exp); end
    end
    eret = 1; epc_q = 32'h200;
    step();
    checks++; if (obs !== exp || a_rpc !== 32'h200 || a_ctl[3:2] !== 2'b11) begin errors++; $display("FAIL eret_rpc act=%h exp=200", a_rpc); end
    eret = 0;
    step();
    checks++; if (obs !== exp || a_ctl[5:2] !== 4'b0010) begin errors++; $display("FAIL return_no_take act=%h exp=%h", obs, exp); end
    step();
    checks++; if (obs !== exp || a_ctl[5] !== 1'b1 || a_cause !== 32'h0 || a_epc !== 32'h600) begin errors++; $display("FAIL pend_after_ret act=%h exp=%h", obs, exp); end
    leave_handler(32'h600);
  endtask

  task automatic test_stall_bubble();
    ex_valid = 1; stall = 1; exc_ov = 1;
    step();
    checks++; if (obs !== exp || a_ctl !== 6'b0) begin errors++; $display("FAIL stall_no_take act=%h exp=%h", obs, exp); end
    ex_valid = 0; stall = 0;
    step();
    checks++; if (obs !== exp || a_ctl !== 6'b0) begin errors++; $display("FAIL bubble_no_take act=%h exp=%h", obs, exp); end
    ex_valid = 1;
    step();
    idle_inputs();
    step();
    ex_valid = 1; exc_ri = 1;
    step();
    checks++; if (obs !== exp || a_ctl[5:4] !== 2'b00) begin errors++; $display("FAIL nested_no_write act=%h exp=%h", obs, exp); end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (obs !== exp || a_ctl[0] !== 1'b1) begin errors++; $display("FAIL nested_sticky act=%h exp=%h", obs, exp); end
    end
    ex_valid = 1; eret = 1; epc_q = 32'h80;
    step();
    idle_inputs();
    step();
    step();
    checks++; if (obs !== exp || a_ctl !== 6'b000001) begin errors++; $display("FAIL nested_idle act=%h exp=%h", obs, exp); end
  endtask

  task automatic test_async_reset();
    ex_valid = 1; exc_ov = 1; ex_pc = 32'h40;
    step();
    idle_inputs();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL enter_flush act=%b exp=1", flush); end
    #2 rst = 1;
    #1;
    checks++; if ({cause_write, epc_write, flush, redirect, in_handler, nested_err, cause_data, epc_data, redirect_pc} !== '0) begin
      errors++; $display("FAIL async_rst act=%b%b%b%b%b%b exp=0", cause_write, epc_write, flush, redirect, in_handler, nested_err); end
    step();
    rst = 0;
    step();
    checks++; if (obs !== exp || a_ctl !== 6'b0) begin errors++; $display("FAIL post_rst_idle act=%h exp=%h", obs, exp); end
    ex_valid = 1; exc_ov = 1;
    step();
    checks++; if (obs !== exp || a_ctl[5] !== 1'b1) begin errors++; $display("FAIL post_rst_take act=%h exp=%h", obs, exp); end
    leave_handler(32'h44);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(63) == 0);
      ex_valid = ($urandom_range(3) != 0);
      stall    = ($urandom_range(4) == 0);
      exc_ov   = ($urandom_range(9) == 0);
      exc_ri   = ($urandom_range(9) == 0);
      exc_sys  = ($urandom_range(9) == 0);
      eret     = ($urandom_range(2) == 0);
      if ($urandom_range(5) == 0) ext_intr = ~ext_intr;
      ex_pc = $urandom;
      epc_q = $urandom;
      step();
      checks++; if (obs !== exp) begin errors++; $display("FAIL random i=%0d act=%h exp=%h", i, obs, exp); end
    end
    rst = 0; ext_intr = 0; idle_inputs();
  endtask

  initial begin
    m_mode = M_IDLE; m_pend = 0; m_nerr = 0;
    for (int i = 0; i < 4; i++) samp[i] = 0;
    test_reset();
    test_overflow();
    test_priority();
    test_ext_intr();
    test_mask_return();
    test_stall_bubble();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
